// File: rtl/move_dispatcher.sv
// Buffers one packed move sequence and issues it move by move to the stepper driver,
// using the move_start/move_done handshake with a settle gap between moves.
module move_dispatcher #(
  parameter int MOVE_W        = 4,
  parameter int MAX_MOVES     = 50,
  parameter int SETTLE_CYCLES = 250000,
  parameter int TIMEOUT       = 50000000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        load,
  input  logic [MOVE_W*MAX_MOVES-1:0] seq,
  input  logic                        go,
  input  logic                        abort,
  input  logic                        move_done,
  output logic [MOVE_W-1:0]           next_move,
  output logic                        move_start,
  output logic [7:0]                  num_moves,
  output logic [7:0]                  curr_step,
  output logic                        busy,
  output logic                        seq_done,
  output logic                        fault
);
  localparam int SEQ_W = MOVE_W * MAX_MOVES;
  localparam int IDX_W = (MAX_MOVES > 1) ? $clog2(MAX_MOVES) : 1;
  localparam logic [MOVE_W-1:0] CODE_MIN = MOVE_W'(2);
  localparam logic [MOVE_W-1:0] CODE_MAX = MOVE_W'(13);
  localparam logic [7:0]        MAX_IDX  = 8'(MAX_MOVES);
  localparam logic [31:0]       SETTLE_LAST  = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0]       TIMEOUT_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_READY, S_ISSUE, S_WAIT_DONE, S_SETTLE, S_FAULT
  } state_t;

  state_t             state_q, state_d;
  logic [SEQ_W-1:0]   buf_q, buf_d;
  logic [7:0]         num_q, num_d;
  logic [7:0]         idx_q, idx_d;
  logic [7:0]         step_q, step_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [MOVE_W-1:0]  next_move_q, next_move_d;
  logic               go_pend_q, go_pend_d;
  logic               abort_pend_q, abort_pend_d;
  logic               seq_done_q, seq_done_d;

  logic [MOVE_W-1:0]  buf_nib [MAX_MOVES];
  logic [MOVE_W-1:0]  scan_code;
  logic [MOVE_W-1:0]  issue_code;
  logic [IDX_W-1:0]   issue_idx;

  for (genvar g = 0; g < MAX_MOVES; g++) begin : g_nib
    assign buf_nib[g] = buf_q[g*MOVE_W +: MOVE_W];
  end

  // Entering ISSUE from READY always restarts at move 0; from SETTLE it uses the advanced step.
  assign issue_idx  = (state_q == S_READY) ? '0 : step_q[IDX_W-1:0];
  assign scan_code  = buf_nib[idx_q[IDX_W-1:0]];
  assign issue_code = buf_nib[issue_idx];

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    num_d        = num_q;
    idx_d        = idx_q;
    step_d       = step_q;
    cnt_d        = cnt_q;
    next_move_d  = next_move_q;
    go_pend_d    = go_pend_q;
    abort_pend_d = abort_pend_q;
    seq_done_d   = 1'b0;

    if (abort && (state_q == S_ISSUE || state_q == S_WAIT_DONE || state_q == S_SETTLE))
      abort_pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (load) begin
          buf_d   = seq;
          num_d   = '0;
          idx_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (go) go_pend_d = 1'b1;
        if (idx_q == MAX_IDX || scan_code < CODE_MIN || scan_code > CODE_MAX) begin
          state_d = S_READY;
        end else begin
          num_d = num_q + 8'd1;
          idx_d = idx_q + 8'd1;
        end
      end
      S_READY: begin
        abort_pend_d = 1'b0;
        // A load here takes priority; a simultaneous go survives the rescan as go_pend.
        if (load) begin
          buf_d     = seq;
          num_d     = '0;
          idx_d     = '0;
          go_pend_d = go_pend_q | go;
          state_d   = S_SCAN;
        end else if (go || go_pend_q) begin
          go_pend_d = 1'b0;
          step_d    = '0;
          if (num_q == 8'd0) seq_done_d = 1'b1;
          else               state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (move_done) begin
          step_d  = step_q + 8'd1;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          if (abort_pend_d || step_q == num_q) begin
            seq_done_d   = 1'b1;
            abort_pend_d = 1'b0;
            state_d      = S_READY;
          end else begin
            state_d = S_ISSUE;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: ;
    endcase

    if (state_d == S_ISSUE && state_q != S_ISSUE) next_move_d = issue_code;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      num_q        <= '0;
      idx_q        <= '0;
      step_q       <= '0;
      cnt_q        <= '0;
      next_move_q  <= '0;
      go_pend_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      seq_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      idx_q        <= idx_d;
      step_q       <= step_d;
      cnt_q        <= cnt_d;
      next_move_q  <= next_move_d;
      go_pend_q    <= go_pend_d;
      abort_pend_q <= abort_pend_d;
      seq_done_q   <= seq_done_d;
    end
  end

  // Buffer contents are meaningless until a load, so they carry no reset.
  always_ff @(posedge clock) begin
    buf_q <= buf_d;
  end

  assign next_move  = next_move_q;
  assign move_start = (state_q == S_ISSUE);
  assign num_moves  = num_q;
  assign curr_step  = step_q;
  assign busy       = (state_q == S_SCAN) || (state_q == S_ISSUE) ||
                      (state_q == S_WAIT_DONE) || (state_q == S_SETTLE);
  assign seq_done   = seq_done_q;
  assign fault      = (state_q == S_FAULT);

endmodule

// File: tb/tb_move_dispatcher.sv
// Self-checking bench for move_dispatcher: table of sequences, hand-written corner
// sequences and randomized sequences checked against a list-based reference model.
module tb_move_dispatcher;
  localparam int MOVE_W    = 4;
  localparam int MAX_MOVES = 50;
  localparam int SETTLE    = 8;
  localparam int TOUT      = 300;
  localparam int SEQ_W     = MOVE_W * MAX_MOVES;

  typedef struct {
    logic [SEQ_W-1:0] seq;
    int               exp_num;
    int               exp_scan;
  } vec_t;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             load = 1'b0, go = 1'b0, abort = 1'b0, move_done = 1'b0;
  logic [SEQ_W-1:0] seq = '0;
  logic [3:0]       next_move;
  logic             move_start, busy, seq_done, fault;
  logic [7:0]       num_moves, curr_step;

  int         tests = 0;
  int         fails = 0;
  int         n_start = 0;
  int         n_sd = 0;
  logic [3:0] model_q[$];
  vec_t       vecs[7];

  move_dispatcher #(
    .MOVE_W(MOVE_W), .MAX_MOVES(MAX_MOVES), .SETTLE_CYCLES(SETTLE), .TIMEOUT(TOUT)
  ) dut (
    .clock(clock), .reset(reset), .load(load), .seq(seq), .go(go), .abort(abort),
    .move_done(move_done), .next_move(next_move), .move_start(move_start),
    .num_moves(num_moves), .curr_step(curr_step), .busy(busy), .seq_done(seq_done),
    .fault(fault)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (move_start === 1'b1) n_start <= n_start + 1;
    if (seq_done === 1'b1)   n_sd    <= n_sd + 1;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: the move list is every nibble from 0 upward until the first code outside 2..13.
  function automatic void model_scan(input logic [SEQ_W-1:0] s);
    logic [SEQ_W-1:0] t;
    t = s;
    model_q.delete();
    for (int k = 0; k < MAX_MOVES; k++) begin
      if (t[3:0] < 4'd2 || t[3:0] > 4'd13) break;
      model_q.push_back(t[3:0]);
      t = t >> 4;
    end
  endfunction

  task automatic rand_seq(output logic [SEQ_W-1:0] s);
    int         n;
    logic [3:0] c;
    n = $urandom_range(0, 14);
    s = '0;
    for (int k = MAX_MOVES - 1; k >= 0; k--) begin
      if (k < n) c = 4'($urandom_range(2, 13));
      else if (k == n) begin
        c = 4'($urandom_range(0, 3));
        if (c >= 4'd2) c = c + 4'd12;
      end else c = 4'($urandom_range(0, 15));
      s = {s[SEQ_W-5:0], c};
    end
  endtask

  task automatic do_load(input logic [SEQ_W-1:0] s, output int scan_len);
    seq  = s;
    load = 1'b1;
    step();
    load = 1'b0;
    scan_len = 0;
    while (busy && scan_len < 100) begin
      scan_len++;
      step();
    end
  endtask

  // Runs the moves in model_q; abort_k >= 0 aborts during that move.
  task automatic play(input int abort_k, input bit abort_with_done, input bit send_go);
    int n_exp, w, d, s0, sd0;
    n_exp = (abort_k >= 0 && abort_k < model_q.size()) ? abort_k + 1 : model_q.size();
    s0  = n_start;
    sd0 = n_sd;
    if (send_go) begin
      go = 1'b1;
      step();
      go = 1'b0;
    end
    if (model_q.size() == 0) begin
      check("empty_seq_done", seq_done, 1);
      check("empty_no_start", move_start, 0);
      step();
      check("empty_done_pulse", seq_done, 0);
    end else begin
      for (int k = 0; k < n_exp; k++) begin
        w = 0;
        while (!move_start && w < SETTLE + 4) begin
          step();
          w++;
        end
        check("start_gap", w, (k == 0) ? 0 : SETTLE);
        check("next_move", next_move, model_q[k]);
        check("curr_step_issue", curr_step, k);
        step();
        check("start_one_cycle", move_start, 0);
        d = $urandom_range(1, 12);
        for (int j = 0; j < d; j++) begin
          abort = (abort_k == k && !abort_with_done && j == 0);
          step();
        end
        move_done = 1'b1;
        abort = (abort_k == k && abort_with_done);
        step();
        move_done = 1'b0;
        abort = 1'b0;
      end
      w = 0;
      while (!seq_done && w < SETTLE + 4) begin
        step();
        w++;
      end
      check("done_gap", w, SETTLE);
      check("final_step", curr_step, n_exp);
      check("ready_not_busy", busy, 0);
      step();
    end
    check("start_count", n_start - s0, n_exp);
    check("seq_done_count", n_sd - sd0, 1);
  endtask

  initial begin
    int         scan, w;
    logic [SEQ_W-1:0] s;

    vecs[0] = '{seq: SEQ_W'(12'hD42),                   exp_num: 3,  exp_scan: 4};
    vecs[1] = '{seq: {MAX_MOVES{4'h6}},                 exp_num: 50, exp_scan: 51};
    vecs[2] = '{seq: '0,                                exp_num: 0,  exp_scan: 1};
    vecs[3] = '{seq: SEQ_W'(12'h715),                   exp_num: 1,  exp_scan: 2};
    vecs[4] = '{seq: SEQ_W'(52'h3ECBA98765432),         exp_num: 11, exp_scan: 12};
    vecs[5] = '{seq: SEQ_W'(8'h2E),                     exp_num: 0,  exp_scan: 1};
    vecs[6] = '{seq: {4'h0, {(MAX_MOVES-1){4'hD}}},     exp_num: 49, exp_scan: 50};

    step();
    step();
    reset = 1'b0;
    check("reset_state", {next_move, move_start, num_moves, curr_step, busy, seq_done, fault}, 0);
    go = 1'b1;
    step();
    go = 1'b0;
    check("idle_go_ignored", {busy, move_start, seq_done}, 0);

    for (int i = 0; i < 7; i++) begin
      model_scan(vecs[i].seq);
      do_load(vecs[i].seq, scan);
      check("table_scan_len", scan, vecs[i].exp_scan);
      check("table_num_moves", num_moves, vecs[i].exp_num);
      play(-1, 1'b0, 1'b1);
    end

    // Abort during move 1, replay, then abort coinciding with move_done.
    s = SEQ_W'(20'h65432);
    model_scan(s);
    do_load(s, scan);
    check("abort_num", num_moves, 5);
    play(1, 1'b0, 1'b1);
    check("abort_curr_step", curr_step, 2);
    play(-1, 1'b0, 1'b1);
    play(2, 1'b1, 1'b1);

    // go arriving during SCAN is held until READY.
    s = SEQ_W'(12'hD42);
    model_scan(s);
    seq  = s;
    load = 1'b1;
    step();
    load = 1'b0;
    go   = 1'b1;
    step();
    go = 1'b0;
    w  = 0;
    while (!move_start && w < 60) begin
      step();
      w++;
    end
    check("gopend_latency", w, 4);
    play(-1, 1'b0, 1'b0);

    // load and go together in READY: rescan, then start.
    s = SEQ_W'(20'h65432);
    model_scan(s);
    seq  = s;
    load = 1'b1;
    go   = 1'b1;
    step();
    load = 1'b0;
    go   = 1'b0;
    w    = 0;
    while (!move_start && w < 60) begin
      step();
      w++;
    end
    check("loadgo_latency", w, 7);
    check("loadgo_num", num_moves, 5);
    play(-1, 1'b0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      rand_seq(s);
      model_scan(s);
      do_load(s, scan);
      check("rand_scan_len", scan, model_q.size() + 1);
      check("rand_num_moves", num_moves, model_q.size());
      if (model_q.size() > 0 && $urandom_range(0, 2) == 0)
        play($urandom_range(0, model_q.size() - 1), 1'($urandom_range(0, 1)), 1'b1);
      else
        play(-1, 1'b0, 1'b1);
    end

    // Reset while waiting for move_done.
    s = SEQ_W'(12'hD42);
    do_load(s, scan);
    go = 1'b1;
    step();
    go = 1'b0;
    step();
    check("in_wait_busy", busy, 1);
    reset = 1'b1;
    step();
    check("reset_mid_move", {next_move, move_start, num_moves, curr_step, busy, seq_done, fault}, 0);
    reset = 1'b0;
    step();

    // Timeout into FAULT, inputs ignored, reset recovers.
    do_load(s, scan);
    go = 1'b1;
    step();
    go = 1'b0;
    check("tout_start", move_start, 1);
    w = 0;
    while (!fault && w < TOUT + 10) begin
      step();
      w++;
    end
    check("tout_cycles", w, TOUT + 1);
    check("fault_not_busy", busy, 0);
    w = n_start;
    seq  = {MAX_MOVES{4'h6}};
    load = 1'b1;
    step();
    load = 1'b0;
    go   = 1'b1;
    step();
    go        = 1'b0;
    move_done = 1'b1;
    step();
    move_done = 1'b0;
    for (int j = 0; j < 5; j++) step();
    check("fault_sticky", fault, 1);
    check("fault_num_kept", num_moves, 3);
    check("fault_no_start", n_start - w, 0);
    check("fault_busy_low", busy, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("fault_reset", {fault, busy, num_moves, curr_step}, 0);
    model_scan(s);
    do_load(s, scan);
    check("post_fault_scan", scan, 4);
    check("post_fault_num", num_moves, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
